// File: rtl/sys_cmd_ctrl_pkg.sv
// sys_cmd_ctrl_pkg: state encoding and command codes shared by the command controller.
package sys_cmd_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        OP_A,
        OP_B,
        FUN,
        ALU_WAIT,
        TX
    } state_t;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

endpackage

// File: rtl/sys_cmd_ctrl_if.sv
// sys_cmd_ctrl_if: frame, register-file, ALU and TX FIFO signals of the command controller.
interface sys_cmd_ctrl_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16,
    parameter int ADDR_WIDTH    = 4
);
    logic [DATA_WIDTH-1:0]    RX_P_Data;
    logic                     RX_D_VLD;
    logic [ALU_OUT_WIDTH-1:0] ALU_OUT;
    logic                     OUT_Valid;
    logic [DATA_WIDTH-1:0]    RdData;
    logic                     RdData_Valid;
    logic                     wfull;
    logic                     ALU_EN;
    logic [3:0]               ALU_FUN;
    logic                     CLK_GATING_EN;
    logic [ADDR_WIDTH-1:0]    Address;
    logic                     Wr_En;
    logic                     Rd_En;
    logic [DATA_WIDTH-1:0]    Wr_Data;
    logic [DATA_WIDTH-1:0]    TX_P_Data;
    logic                     TX_D_VLD;
    logic                     clk_div_en;
    logic                     cmd_err;

    modport master (
        input  RX_P_Data, RX_D_VLD, ALU_OUT, OUT_Valid, RdData, RdData_Valid, wfull,
        output ALU_EN, ALU_FUN, CLK_GATING_EN, Address, Wr_En, Rd_En, Wr_Data,
               TX_P_Data, TX_D_VLD, clk_div_en, cmd_err
    );

    modport slave (
        output RX_P_Data, RX_D_VLD, ALU_OUT, OUT_Valid, RdData, RdData_Valid, wfull,
        input  ALU_EN, ALU_FUN, CLK_GATING_EN, Address, Wr_En, Rd_En, Wr_Data,
               TX_P_Data, TX_D_VLD, clk_div_en, cmd_err
    );

endinterface

// File: rtl/sys_cmd_tx_ser.sv
// sys_cmd_tx_ser: holds a read byte or ALU result and streams it LSB byte first into the TX FIFO.
module sys_cmd_tx_ser #(
    parameter int DATA_WIDTH    = 8,
    parameter int ALU_OUT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     load_rd,
    input  logic                     load_alu,
    input  logic                     active,
    input  logic                     wfull,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    input  logic [ALU_OUT_WIDTH-1:0] alu_out,
    output logic [DATA_WIDTH-1:0]    tx_data,
    output logic                     tx_vld,
    output logic                     done
);
    localparam int NB = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int IW = $clog2(NB + 1);

    logic [ALU_OUT_WIDTH-1:0] res_q, res_d;
    logic [IW-1:0]            idx_q, idx_d, cnt_q, cnt_d;
    logic                     xfer;

    always_comb begin
        xfer    = active && !wfull;
        done    = xfer && (idx_q == cnt_q - IW'(1));
        res_d   = load_alu ? alu_out : load_rd ? ALU_OUT_WIDTH'(rd_data) : res_q;
        cnt_d   = load_alu ? IW'(NB) : load_rd ? IW'(1) : cnt_q;
        idx_d   = (load_alu || load_rd || done) ? '0 : xfer ? idx_q + IW'(1) : idx_q;
        tx_vld  = active;
        tx_data = active ? res_q[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            res_q <= '0;
            idx_q <= '0;
            cnt_q <= '0;
        end else begin
            res_q <= res_d;
            idx_q <= idx_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: frame command decoder driving register file, ALU and TX FIFO.
// Optional idle-wait watchdog is built when SYS_CMD_CTRL_TIMEOUT_EN is defined.
module sys_cmd_ctrl
    import sys_cmd_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ALU_OUT_WIDTH  = 16,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic            CLK,
    input logic            RST,
    sys_cmd_ctrl_if.master bus
);
    state_t                state_q, state_d, fsm_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  load_rd, load_alu, fsm_err, tx_done;
    logic [DATA_WIDTH-1:0] rx;

    assign rx             = bus.RX_P_Data;
    assign bus.clk_div_en = 1'b1;

    always_comb begin
        fsm_d             = state_q;
        addr_d            = addr_q;
        fsm_err           = 1'b0;
        load_rd           = 1'b0;
        load_alu          = 1'b0;
        bus.ALU_EN        = 1'b0;
        bus.ALU_FUN       = '0;
        bus.CLK_GATING_EN = 1'b0;
        bus.Address       = '0;
        bus.Wr_En         = 1'b0;
        bus.Rd_En         = 1'b0;
        bus.Wr_Data       = '0;
        case (state_q)
            IDLE: begin
                fsm_d   = !bus.RX_D_VLD ? IDLE :
                          rx == DATA_WIDTH'(CMD_RF_WR)   ? WR_ADDR :
                          rx == DATA_WIDTH'(CMD_RF_RD)   ? RD_ADDR :
                          rx == DATA_WIDTH'(CMD_ALU_OP)  ? OP_A :
                          rx == DATA_WIDTH'(CMD_ALU_NOP) ? FUN : IDLE;
                fsm_err = bus.RX_D_VLD && fsm_d == IDLE;
            end
            WR_ADDR: if (bus.RX_D_VLD) begin
                addr_d = rx[ADDR_WIDTH-1:0];
                fsm_d  = WR_DATA;
            end
            WR_DATA: if (bus.RX_D_VLD) begin
                bus.Wr_En   = 1'b1;
                bus.Address = addr_q;
                bus.Wr_Data = rx;
                fsm_d       = IDLE;
            end
            RD_ADDR: if (bus.RX_D_VLD) begin
                bus.Rd_En   = 1'b1;
                bus.Address = rx[ADDR_WIDTH-1:0];
                fsm_d       = RD_WAIT;
            end
            RD_WAIT: if (bus.RdData_Valid) begin
                load_rd = 1'b1;
                fsm_d   = TX;
            end
            OP_A, OP_B: if (bus.RX_D_VLD) begin
                bus.Wr_En   = 1'b1;
                bus.Address = state_q == OP_B ? ADDR_WIDTH'(1) : '0;
                bus.Wr_Data = rx;
                fsm_d       = state_q == OP_B ? FUN : OP_B;
            end
            FUN: begin
                bus.CLK_GATING_EN = 1'b1;
                if (bus.RX_D_VLD) begin
                    bus.ALU_EN  = 1'b1;
                    bus.ALU_FUN = rx[3:0];
                    fsm_d       = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                bus.CLK_GATING_EN = 1'b1;
                if (bus.OUT_Valid) begin
                    load_alu = 1'b1;
                    fsm_d    = TX;
                end
            end
            TX: fsm_d = tx_done ? IDLE : TX;
            default: fsm_d = IDLE;
        endcase
    end

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WW-1:0] wd_q, wd_d;
    logic          waiting, timeout;

    // Counts consecutive silent cycles in a wait state; any strobe or state change restarts it.
    always_comb begin
        waiting = state_q != IDLE && state_q != TX &&
                  !(bus.RX_D_VLD || bus.RdData_Valid || bus.OUT_Valid);
        timeout = waiting && wd_q == WW'(TIMEOUT_CYCLES - 1);
        wd_d    = (waiting && !timeout && fsm_d == state_q) ? wd_q + WW'(1) : '0;
        state_d = timeout ? IDLE : fsm_d;
        bus.cmd_err = fsm_err || timeout;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) wd_q <= '0;
        else      wd_q <= wd_d;
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign state_d        = fsm_d;
    assign bus.cmd_err    = fsm_err;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    sys_cmd_tx_ser #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ALU_OUT_WIDTH(ALU_OUT_WIDTH)
    ) u_tx_ser (
        .CLK     (CLK),
        .RST     (RST),
        .load_rd (load_rd),
        .load_alu(load_alu),
        .active  (state_q == TX),
        .wfull   (bus.wfull),
        .rd_data (bus.RdData),
        .alu_out (bus.ALU_OUT),
        .tx_data (bus.TX_P_Data),
        .tx_vld  (bus.TX_D_VLD),
        .done    (tx_done)
    );

endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: transaction-level model of sys_cmd_ctrl with per-cycle output comparison.
module tb_sys_cmd_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    always #5 CLK = ~CLK;

    sys_cmd_ctrl_if #(.DATA_WIDTH(8), .ALU_OUT_WIDTH(16), .ADDR_WIDTH(4)) bus ();

    sys_cmd_ctrl #(
        .DATA_WIDTH    (8),
        .ALU_OUT_WIDTH (16),
        .ADDR_WIDTH    (4),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.master)
    );

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [3:0] exp_rd[$];
    logic [3:0] exp_alu[$];
    logic [7:0] exp_tx[$];
    logic [7:0] obs_tx[$];
    int         exp_err   = 0;
    bit         gate_exp  = 0;
    int         errors    = 0;
    int         checks    = 0;
    int         stall_cnt = 0;
    int         err_seen  = 0;
    logic [3:0] last_wa, last_ra;
    logic [7:0] last_wd;
    wr_t        w_cur;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Expected events are queued by the stimulus; every cycle the DUT outputs must match them.
    always @(negedge CLK) if (RST) begin
        chk("clk_div_en", bus.clk_div_en, 1);
        chk("clk_gating_en", bus.CLK_GATING_EN, gate_exp);
        if (bus.Wr_En) begin
            chk("wr_expected", exp_wr.size() != 0, 1);
            if (exp_wr.size() != 0) begin
                w_cur = exp_wr.pop_front();
                chk("wr_addr", bus.Address, w_cur.a);
                chk("wr_data", bus.Wr_Data, w_cur.d);
            end
            last_wa = bus.Address;
            last_wd = bus.Wr_Data;
        end else chk("wr_data_idle", bus.Wr_Data, 0);
        if (bus.Rd_En) begin
            chk("rd_expected", exp_rd.size() != 0, 1);
            if (exp_rd.size() != 0) chk("rd_addr", bus.Address, exp_rd.pop_front());
            last_ra = bus.Address;
        end
        if (!bus.Wr_En && !bus.Rd_En) chk("addr_idle", bus.Address, 0);
        if (bus.ALU_EN) begin
            chk("alu_expected", exp_alu.size() != 0, 1);
            if (exp_alu.size() != 0) chk("alu_fun", bus.ALU_FUN, exp_alu.pop_front());
        end else chk("alu_fun_idle", bus.ALU_FUN, 0);
        chk("tx_vld", bus.TX_D_VLD, exp_tx.size() != 0);
        if (exp_tx.size() != 0) begin
            chk("tx_data", bus.TX_P_Data, exp_tx[0]);
            if (bus.wfull) stall_cnt++;
            else begin
                obs_tx.push_back(bus.TX_P_Data);
                void'(exp_tx.pop_front());
            end
        end else chk("tx_data_idle", bus.TX_P_Data, 0);
        if (bus.cmd_err) begin
            chk("err_expected", exp_err > 0, 1);
            if (exp_err > 0) exp_err--;
            err_seen++;
        end
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic gap();
        cyc($urandom_range(0, 3));
    endtask

    task automatic send(logic [7:0] b);
        bus.RX_P_Data = b;
        bus.RX_D_VLD  = 1'b1;
        cyc(1);
        bus.RX_D_VLD  = 1'b0;
        bus.RX_P_Data = 8'($urandom);
    endtask

    // Stray RX strobes while waiting must be ignored.
    task automatic noisy_wait(int n);
        repeat (n) begin
            bus.RX_D_VLD  = $urandom_range(0, 2) == 0;
            bus.RX_P_Data = 8'($urandom);
            cyc(1);
        end
        bus.RX_D_VLD = 1'b0;
    endtask

    task automatic drain_tx(bit rnd);
        int n = 0;
        while (exp_tx.size() != 0 && n < 60) begin
            bus.wfull     = rnd && $urandom_range(0, 2) == 0;
            bus.RX_D_VLD  = $urandom_range(0, 2) == 0;
            bus.RX_P_Data = 8'($urandom);
            cyc(1);
            n++;
        end
        bus.wfull    = 1'b0;
        bus.RX_D_VLD = 1'b0;
        if (exp_tx.size() != 0) chk("tx_drain_bound", exp_tx.size(), 0);
        exp_tx.delete();
    endtask

    task automatic do_write(logic [3:0] a, logic [7:0] d);
        exp_wr.push_back({a, d});
        send(8'hAA);
        gap();
        send({4'($urandom), a});
        gap();
        send(d);
    endtask

    task automatic do_read(logic [3:0] a, logic [7:0] d, bit rnd);
        exp_rd.push_back(a);
        send(8'hBB);
        gap();
        send({4'($urandom), a});
        noisy_wait($urandom_range(0, 4));
        bus.RdData       = d;
        bus.RdData_Valid = 1'b1;
        cyc(1);
        bus.RdData_Valid = 1'b0;
        bus.RdData       = 8'($urandom);
        exp_tx.push_back(d);
        drain_tx(rnd);
    endtask

    task automatic alu_fun(logic [7:0] f);
        gate_exp = 1'b1;
        exp_alu.push_back(f[3:0]);
        gap();
        send(f);
    endtask

    task automatic alu_front(logic [7:0] a, logic [7:0] b, logic [7:0] f);
        exp_wr.push_back({4'd0, a});
        exp_wr.push_back({4'd1, b});
        send(8'hCC);
        gap();
        send(a);
        gap();
        send(b);
        alu_fun(f);
    endtask

    task automatic alu_result(logic [15:0] r);
        noisy_wait($urandom_range(0, 4));
        bus.ALU_OUT   = r;
        bus.OUT_Valid = 1'b1;
        cyc(1);
        bus.OUT_Valid = 1'b0;
        bus.ALU_OUT   = 16'($urandom);
        gate_exp      = 1'b0;
        exp_tx.push_back(r[7:0]);
        exp_tx.push_back(r[15:8]);
    endtask

    task automatic do_bad(logic [7:0] b);
        exp_err++;
        send(b);
    endtask

    task automatic outputs_reset(string tag);
        chk({tag, "_alu_en"}, bus.ALU_EN, 0);
        chk({tag, "_alu_fun"}, bus.ALU_FUN, 0);
        chk({tag, "_gate"}, bus.CLK_GATING_EN, 0);
        chk({tag, "_addr"}, bus.Address, 0);
        chk({tag, "_wr_en"}, bus.Wr_En, 0);
        chk({tag, "_rd_en"}, bus.Rd_En, 0);
        chk({tag, "_wr_data"}, bus.Wr_Data, 0);
        chk({tag, "_tx_data"}, bus.TX_P_Data, 0);
        chk({tag, "_tx_vld"}, bus.TX_D_VLD, 0);
        chk({tag, "_clk_div_en"}, bus.clk_div_en, 1);
        chk({tag, "_cmd_err"}, bus.cmd_err, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got running want finished");
        $fatal(1);
    end

    initial begin
        int e0, n0, s0, n, kind;
        logic [7:0] b;
        bus.RX_P_Data    = '0;
        bus.RX_D_VLD     = 1'b0;
        bus.ALU_OUT      = '0;
        bus.OUT_Valid    = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.wfull        = 1'b0;
        #2;
        outputs_reset("reset");
        cyc(2);
        RST = 1'b1;
        cyc(2);

        // Register write: AA 05 3C
        do_write(4'h5, 8'h3C);
        chk("req028_addr", last_wa, 4'h5);
        chk("req028_data", last_wd, 8'h3C);

        // Register read: BB 05, data 3C returned through TX
        n0 = obs_tx.size();
        do_read(4'h5, 8'h3C, 0);
        chk("req029_rd_addr", last_ra, 4'h5);
        chk("req029_tx_count", obs_tx.size() - n0, 1);
        chk("req029_tx_byte", obs_tx[n0], 8'h3C);

        // ALU op with a three-cycle FIFO stall on the first byte
        n0 = obs_tx.size();
        s0 = stall_cnt;
        alu_front(8'h10, 8'h20, 8'h00);
        alu_result(16'h1234);
        bus.wfull = 1'b1;
        cyc(3);
        bus.wfull = 1'b0;
        drain_tx(0);
        chk("req030_stall", stall_cnt - s0, 3);
        chk("req030_count", obs_tx.size() - n0, 2);
        chk("req030_byte0", obs_tx[n0], 8'h34);
        chk("req030_byte1", obs_tx[n0+1], 8'h12);

        // Unknown command
        e0 = err_seen;
        do_bad(8'h55);
        cyc(1);
        chk("req031_err_pulses", err_seen - e0, 1);
        do_write(4'hA, 8'h5A);
        chk("req031_idle_after", last_wd, 8'h5A);

`ifdef SYS_CMD_CTRL_TIMEOUT_EN
        e0 = err_seen;
        exp_err++;
        send(8'hAA);
        n = 0;
        while (err_seen == e0 && n < 400) begin
            cyc(1);
            n++;
        end
        chk("req032_timeout_cycles", n, 255);
        do_write(4'h3, 8'hC3);
        chk("req032_idle_after", last_wd, 8'hC3);
`endif

        // Reset during the second TX byte
        alu_front(8'h01, 8'h02, 8'h03);
        alu_result(16'hBEEF);
        n = 0;
        while (exp_tx.size() == 2 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("req033_first_byte", exp_tx.size(), 1);
        chk("req033_second_on_bus", bus.TX_P_Data, 8'hBE);
        #1;
        RST = 1'b0;
        #1;
        outputs_reset("req033");
        exp_tx.delete();
        cyc(2);
        RST = 1'b1;
        cyc(3);
        do_read(4'h7, 8'h99, 0);
        chk("req033_read_after", obs_tx[obs_tx.size()-1], 8'h99);

        // Randomized command mix
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            gap();
            case (kind)
                0: do_write(4'($urandom), 8'($urandom));
                1: do_read(4'($urandom), 8'($urandom), 1);
                2: begin
                    alu_front(8'($urandom), 8'($urandom), 8'($urandom));
                    alu_result(16'($urandom));
                    drain_tx(1);
                end
                3: begin
                    send(8'hDD);
                    alu_fun(8'($urandom));
                    alu_result(16'($urandom));
                    drain_tx(1);
                end
                default: begin
                    b = 8'($urandom);
                    while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
                    do_bad(b);
                end
            endcase
        end
        cyc(3);
        chk("end_wr_queue", exp_wr.size(), 0);
        chk("end_rd_queue", exp_rd.size(), 0);
        chk("end_alu_queue", exp_alu.size(), 0);
        chk("end_err_pending", exp_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
